// File: rtl/mac_accumulate_stage.sv
// Sequential wrapper around an external 8x8 combinational multiplier: registers operand
// beats onto the multiplier, accumulates the products per burst and hands off the result.
module mac_accumulate_stage #(
    parameter int ACC_W   = 24,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_a,
    input  logic [7:0]         in_b,
    input  logic               in_last,
    output logic [7:0]         mul_a,
    output logic [7:0]         mul_b,
    input  logic [15:0]        mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_overflow
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t             r_state;
    logic [7:0]         r_mul_a;
    logic [7:0]         r_mul_b;
    logic               r_vld_q;
    logic               r_last_q;
    logic [ACC_W-1:0]   r_acc;
    logic [COUNT_W-1:0] r_count;
    logic               r_ovf;

    logic               w_accept;
    logic               w_release;
    logic               w_count_max;
    logic [ACC_W:0]     w_sum;

    assign in_ready     = (r_state == ST_RUN);
    assign out_valid    = (r_state == ST_DONE);
    assign w_accept     = in_valid & in_ready;
    assign w_release    = (r_state == ST_DONE) & out_ready;
    assign w_count_max  = &r_count;
    // One extra bit on the left captures the carry-out for the sticky overflow flag.
    assign w_sum        = {1'b0, r_acc} + {{(ACC_W + 1 - 16){1'b0}}, mul_product};

    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign out_acc      = r_acc;
    assign out_count    = r_count;
    assign out_overflow = r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_vld_q  <= 1'b0;
            r_last_q <= 1'b0;
        end else begin
            r_vld_q <= w_accept;
            if (w_accept) begin
                r_mul_a  <= in_a;
                r_mul_b  <= in_b;
                r_last_q <= in_last;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_accept && in_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // r_last_q is always set here; it ties the hand-off to the tagged beat.
                    if (r_last_q) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (r_vld_q) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            if (!w_count_max) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Bench for mac_accumulate_stage: two instances (24-bit and 16-bit accumulators) share one
// operand stream; each burst is scored against plain-arithmetic sums of the operand products.
module tb_mac_accumulate_stage;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        in_last   = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_a      = 8'd0;
    logic [7:0]  in_b      = 8'd0;

    logic        in_ready, out_valid, out_overflow;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_product;
    logic [23:0] out_acc;
    logic [7:0]  out_count;

    logic        in_ready_16, out_valid_16, out_overflow_16;
    logic [7:0]  mul_a_16, mul_b_16;
    logic [15:0] mul_product_16;
    logic [15:0] out_acc_16;
    logic [7:0]  out_count_16;

    int n_checks = 0;
    int n_errors = 0;
    int n_bursts = 0;

    int q_a[$];
    int q_b[$];
    int q_gap[$];

    always #5 clk = ~clk;

    // Stand-in for the sibling multiplier instances.
    assign mul_product    = 16'(mul_a) * 16'(mul_b);
    assign mul_product_16 = 16'(mul_a_16) * 16'(mul_b_16);

    mac_accumulate_stage #(.ACC_W(24), .COUNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_overflow(out_overflow)
    );

    mac_accumulate_stage #(.ACC_W(16), .COUNT_W(8)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_16), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_a(mul_a_16), .mul_b(mul_b_16), .mul_product(mul_product_16),
        .out_valid(out_valid_16), .out_ready(out_ready),
        .out_acc(out_acc_16), .out_count(out_count_16), .out_overflow(out_overflow_16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input int a, input int b, input int gap);
        q_a.push_back(a);
        q_b.push_back(b);
        q_gap.push_back(gap);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the queued beats as one burst, then holds the result for 'hold' cycles
    // with a competing input beat offered, and finally releases it.
    task automatic run_burst(input int hold);
        longint total = 0;
        int     n     = q_a.size();
        longint exp_acc24, exp_acc16, exp_cnt;
        bit     exp_ovf24, exp_ovf16;
        for (int i = 0; i < n; i++) begin
            in_a     = 8'(q_a[i]);
            in_b     = 8'(q_b[i]);
            in_last  = (i == n - 1);
            in_valid = 1'b1;
            check("in_ready_run", in_ready, 1);
            tick();
            total   += longint'(q_a[i]) * longint'(q_b[i]);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i != n - 1) begin
                repeat (q_gap[i]) tick();
            end
        end
        exp_acc24 = total % (64'd1 << 24);
        exp_acc16 = total % (64'd1 << 16);
        exp_ovf24 = (total >= (64'd1 << 24));
        exp_ovf16 = (total >= (64'd1 << 16));
        exp_cnt   = (n > 255) ? 255 : n;

        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        check("drain_mul_a", mul_a, q_a[n-1]);
        check("drain_mul_b", mul_b, q_b[n-1]);
        tick();
        check("done_out_valid", out_valid, 1);
        check("acc24", out_acc, exp_acc24);
        check("count24", out_count, exp_cnt);
        check("ovf24", out_overflow, exp_ovf24);
        check("acc16", out_acc_16, exp_acc16);
        check("count16", out_count_16, exp_cnt);
        check("ovf16", out_overflow_16, exp_ovf16);
        $display("burst %0d: beats=%0d acc24=%0d count=%0d ovf24=%0d acc16=%0d ovf16=%0d hold=%0d",
                 n_bursts, n, out_acc, out_count, out_overflow, out_acc_16, out_overflow_16, hold);

        in_valid = 1'b1;
        in_a     = 8'($urandom_range(1, 255));
        in_b     = 8'($urandom_range(1, 255));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            tick();
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_acc", out_acc, exp_acc24);
            check("hold_count", out_count, exp_cnt);
            check("hold_ovf", out_overflow, exp_ovf24);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        check("rel_acc", out_acc, 0);
        check("rel_count", out_count, 0);
        check("rel_ovf", out_overflow_16, 0);

        n_bursts++;
        q_a.delete();
        q_b.delete();
        q_gap.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_a", mul_a, 0);
        check("rst_acc", out_acc, 0);
        check("rst_count", out_count, 0);
        check("rst_ovf", out_overflow, 0);
        rst = 1'b0;
        tick();

        // single beat
        add_beat(3, 5, 0);
        run_burst(0);

        // back-to-back full-scale
        for (int i = 0; i < 4; i++) add_beat(255, 255, 0);
        run_burst(0);

        // backpressure, then an independent burst
        add_beat(17, 23, 0);
        run_burst(5);
        add_beat(2, 2, 0);
        run_burst(0);

        // bubbles
        add_beat(1, 1, 3);
        add_beat(2, 3, 1);
        add_beat(4, 4, 0);
        run_burst(1);

        // 16-bit overflow, then a clean burst
        add_beat(255, 255, 0);
        add_beat(255, 255, 0);
        run_burst(0);
        add_beat(10, 10, 0);
        run_burst(0);

        // reset mid-burst
        in_a = 8'd9; in_b = 8'd11; in_valid = 1'b1;
        tick();
        in_a = 8'd13; in_b = 8'd6;
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_mul_a", mul_a, 0);
        check("mrst_mul_b", mul_b, 0);
        check("mrst_acc", out_acc, 0);
        check("mrst_count", out_count, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        add_beat(7, 9, 0);
        run_burst(0);

        // count saturation and 24-bit overflow
        for (int i = 0; i < 300; i++) add_beat(255, 255, 0);
        run_burst(0);

        // randomized bursts
        for (int k = 0; k < 20; k++) begin
            int n    = $urandom_range(1, 12);
            bit full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) begin
                add_beat(full ? 255 : $urandom_range(0, 255),
                         full ? 255 : $urandom_range(0, 255),
                         ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_burst($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
